// File: rtl/chip_input_router.sv
// Routes synchronized pad inputs to per-macro input buses under a drained config switch.
// Optional INPUT_FILTER_EN adds a 3-sample agreement filter after the synchronizers.
module chip_input_router #(
  parameter int       n             = 4,
  parameter int       SYNC_STAGES   = 2,
  parameter int       SETTLE_CYCLES = 4,
  parameter bit [3:0] RESET_CFG     = 4'h0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_req,
  input  logic [3:0]          cfg_in,
  output logic                cfg_ack,
  output logic                cfg_busy,
  output logic [3:0]          configuration,
  input  logic [13:0]         IO_east_i,
  input  logic [13:0]         IO_east_oe,
  input  logic [13:0]         IO_west_i,
  input  logic [13:0]         IO_west_oe,
  input  logic [9:0]          IO_north_i,
  input  logic [9:0]          IO_north_oe,
  output logic [n-1:0][13:0]  east_i,
  output logic [n-1:0][13:0]  west_i,
  output logic [n-1:0][9:0]   north_i
);

  typedef enum logic [1:0] {
    S_ACTIVE,
    S_DRAIN,
    S_LOAD
  } state_t;

  state_t      r_state;
  state_t      w_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  r_pend;
  logic [3:0]  w_cfg;
  logic [1:0]  w_eo;
  logic [1:0]  w_wo;
  logic [1:0]  w_no;
  logic [37:0] w_pad;
  logic [37:0] w_syn;
  logic [37:0] w_dat;
  logic [37:0] r_sync [SYNC_STAGES];

  logic [n-1:0][13:0] w_e;
  logic [n-1:0][13:0] w_w;
  logic [n-1:0][9:0]  w_n;

  assign w_pad = {IO_north_i, IO_west_i, IO_east_i};
  assign w_syn = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        r_sync[i] <= '0;
    end else begin
      r_sync[0] <= w_pad;
      for (int i = 1; i < SYNC_STAGES; i++)
        r_sync[i] <= r_sync[i-1];
    end
  end

`ifdef INPUT_FILTER_EN
  logic [37:0] r_h1;
  logic [37:0] r_h2;
  logic [37:0] r_flt;
  logic [37:0] w_agr;

  // A bit only moves once three successive samples agree.
  assign w_agr = ~(w_syn ^ r_h1) & ~(r_h1 ^ r_h2);
  assign w_dat = (w_agr & w_syn) | (~w_agr & r_flt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h1  <= '0;
      r_h2  <= '0;
      r_flt <= '0;
    end else begin
      r_h1  <= w_syn;
      r_h2  <= r_h1;
      r_flt <= w_dat;
    end
  end
`else
  assign w_dat = w_syn;
`endif

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_ACTIVE: if (cfg_req) w_nxt = S_DRAIN;
      S_DRAIN:  if (r_cnt == 4'd1) w_nxt = S_LOAD;
      S_LOAD:   w_nxt = S_ACTIVE;
      default:  w_nxt = S_ACTIVE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_ACTIVE;
      r_cnt         <= '0;
      r_pend        <= RESET_CFG;
      configuration <= RESET_CFG;
      cfg_ack       <= 1'b0;
    end else begin
      r_state <= w_nxt;
      cfg_ack <= (r_state == S_LOAD);
      if (r_state == S_ACTIVE && cfg_req) begin
        r_pend <= cfg_in;
        r_cnt  <= 4'(SETTLE_CYCLES);
      end else if (r_state == S_DRAIN) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == S_LOAD)
        configuration <= r_pend;
    end
  end

  assign cfg_busy = (r_state != S_ACTIVE);

  // The first ACTIVE cycle after LOAD already uses the new mapping.
  assign w_cfg = (r_state == S_LOAD) ? r_pend : configuration;
  assign w_eo  = w_cfg[1:0];
  assign w_wo  = w_cfg[3:2];
  assign w_no  = w_cfg[1:0] ^ w_cfg[3:2];

  always_comb begin
    w_e = '0;
    w_w = '0;
    w_n = '0;
    if (w_nxt == S_ACTIVE) begin
      for (int m = 0; m < n; m++) begin
        if (w_eo == 2'(m))
          w_e[m] = w_dat[13:0] & ~IO_east_oe;
        if (w_wo == 2'(m))
          w_w[m] = w_dat[27:14] & ~IO_west_oe;
        if (w_no == 2'(m))
          w_n[m] = w_dat[37:28] & ~IO_north_oe;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      east_i  <= '0;
      west_i  <= '0;
      north_i <= '0;
    end else begin
      east_i  <= w_e;
      west_i  <= w_w;
      north_i <= w_n;
    end
  end

endmodule
